mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have port: if_read  in  1  instruction-fetch read request; held until if_ready.
REQ-004 SHALL have port: if_addr  in  32  fetch byte address.
REQ-005 SHALL have port: if_ready  out  1  one-cycle pulse; if_data valid.
REQ-006 SHALL have port: if_data  out  32  fetched instruction, little-endian.
REQ-007 SHALL have ports: mem_read  in  1 and mem_write  in  1  load/store requests; held until mem_ready.
REQ-008 SHALL have ports: mem_addr  in  32 and mem_len  in  2  byte address; length code (0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 4 bytes).
REQ-009 SHALL have ports: mem_wdata  in  32 (store data, low bytes first) and mem_ready  out  1 (one-cycle pulse).
REQ-010 SHALL have port: mem_rdata  out  32  load data, zero-extended above the loaded length.
REQ-011 SHALL have ports: ram_addr  out  32, ram_wr  out  1, ram_dout  out  8, ram_din  in  8  byte-wide RAM; read data for the address presented in cycle t appears on ram_din in cycle t+1.

Function
REQ-012 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-013 SHALL sample requests only in IDLE; a request sampled in cycle S SHALL start the transfer in cycle S+1.
REQ-014 SHALL grant MEM over IF when both request in the same IDLE cycle; arbitration SHALL be non-preemptive.
REQ-015 SHALL treat mem_write=1 with mem_read=1 as a write.
REQ-016 SHALL latch address, length, op and wdata at grant; request-side changes during the transfer SHALL be ignored, except as stated in REQ-021.
REQ-017 SHALL, for an N-byte read, drive ram_addr = base+k in cycle S+1+k for k = 0..N-1, capture ram_din into byte k at the end of cycle S+2+k, and assert ready in cycle S+N+2.
REQ-018 SHALL, for an N-byte write, drive ram_addr = base+k, ram_dout = wdata[8k+7:8k] and ram_wr = 1 in cycle S+1+k, and assert mem_ready in cycle S+N+1.
REQ-019 SHALL compute base+k modulo 2^32 (address wrap-around).
REQ-020 SHALL enter DONE in the ready cycle and return to IDLE the next cycle; a request still high in that IDLE cycle SHALL be a new request.
REQ-021 SHALL abort an IF_RD transfer on the edge where if_read is sampled 0: go to IDLE the next cycle, with no if_ready and no change to if_data.
REQ-022 SHALL keep if_data and mem_rdata stable from their ready pulse until the next completion of the same port.
REQ-023 SHALL drive ram_wr = 0 in every cycle that is not a write byte cycle, and ram_addr = 0 and ram_dout = 0 in IDLE and DONE.
REQ-024 SHALL never assert if_ready and mem_ready in the same cycle.

Reset
REQ-025 SHALL, on reset, enter IDLE and force if_ready = 0, mem_ready = 0, ram_wr = 0, ram_addr = 0, ram_dout = 0, if_data = 0, mem_rdata = 0.
REQ-026 SHALL treat reset mid-transfer the same way: no ready pulse and no further ram_wr after the reset edge.
REQ-027 SHALL sample no request during a reset cycle.

Verification
REQ-028 SHALL cover word fetch: if_read = 1, if_addr = 0x100, RAM bytes 13 05 00 00 -> ram_addr 0x100..0x103 in cycles S+1..S+4, if_ready in S+6, if_data = 0x00000513.
REQ-029 SHALL cover contention: if_read and mem_read (len 0, addr 0x2000, byte 0xAB) both in cycle S -> mem_ready in S+3, mem_rdata = 0x000000AB; IF granted in S+4 and if_ready in S+10.
REQ-030 SHALL cover half store: mem_write = 1, len 1, addr 0xFFFFFFFF, wdata 0x1234 -> ram_wr = 1 at 0xFFFFFFFF with 0x34, then at 0x00000000 with 0x12; mem_ready in S+3.
REQ-031 SHALL cover fetch abort: if_read dropped in cycle S+2 -> IDLE by S+4, no if_ready, if_data unchanged; a pending mem_read is then granted.
REQ-032 SHALL cover reset mid-write: reset in cycle S+2 of a word store -> only the byte at base+0 written, all outputs 0 from the next cycle, no mem_ready.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: fetch port, load/store port and the byte-wide RAM port.
// The controller uses the slave view; the requester/RAM side uses the master view.
interface mem_ctrl_if;
  logic        if_read;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport slave (
    input  if_read, if_addr, mem_read, mem_write, mem_addr, mem_len, mem_wdata, ram_din,
    output if_ready, if_data, mem_ready, mem_rdata, ram_addr, ram_wr, ram_dout
  );

  modport master (
    output if_read, if_addr, mem_read, mem_write, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_ready, if_data, mem_ready, mem_rdata, ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates an instruction-fetch port and a load/store port onto a byte-wide RAM
// with one-cycle read latency; MEM wins contention, transfers are never preempted.
module mem_ctrl (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        is_mem_q, is_mem_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] rd_data;
  logic [2:0]  mem_nbytes;

  assign mem_nbytes = (bus.mem_len == 2'd0) ? 3'd1 : (bus.mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nbytes_d    = nbytes_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    is_mem_d    = is_mem_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    bus.ram_addr = '0;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = '0;
    // ram_din carries the byte addressed in the previous cycle, i.e. byte cnt-1
    rd_data = buf_q;
    for (int i = 0; i < 4; i++)
      if (cnt_q == 3'(i + 1)) rd_data[8*i +: 8] = bus.ram_din;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        buf_d = '0;
        if (bus.mem_write || bus.mem_read) begin
          state_d  = bus.mem_write ? MEM_WR : MEM_RD;
          base_d   = bus.mem_addr;
          nbytes_d = mem_nbytes;
          wdata_d  = bus.mem_wdata;
          is_mem_d = 1'b1;
        end else if (bus.if_read) begin
          state_d  = IF_RD;
          base_d   = bus.if_addr;
          nbytes_d = 3'd4;
          is_mem_d = 1'b0;
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt_q < nbytes_q) bus.ram_addr = base_q + 32'(cnt_q);
        if (state_q == IF_RD && !bus.if_read) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != '0) buf_d = rd_data;
          if (cnt_q == nbytes_q) begin
            state_d = DONE;
            if (is_mem_q) mem_rdata_d = rd_data;
            else          if_data_d   = rd_data;
          end
        end
      end
      MEM_WR: begin
        bus.ram_addr = base_q + 32'(cnt_q);
        bus.ram_wr   = !reset;
        bus.ram_dout = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == nbytes_q - 3'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ready  = (state_q == DONE) && !is_mem_q && !reset;
  assign bus.mem_ready = (state_q == DONE) &&  is_mem_q && !reset;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      is_mem_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nbytes_q    <= nbytes_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      is_mem_q    <= is_mem_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end
endmodule
